// File: rtl/spi_word_sequencer_if.sv
// Bundle of the upstream word port, the shifter start/done port and the rx word port.
//   in_valid/in_data/in_ready      : upstream words to transmit (valid/ready)
//   sh_start/sh_tx_word            : launch of one 32-bit shifter transaction
//   sh_done/sh_rx_word             : shifter completion and captured MISO word
//   rx_valid/rx_data/rx_ready      : received words to the consumer (valid/ready)
// slave is the sequencer's view; master is the view of the surrounding logic.
interface spi_word_sequencer_if;
  localparam int unsigned WORD_W = 32;

  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;
  logic              sh_start;
  logic [WORD_W-1:0] sh_tx_word;
  logic              sh_done;
  logic [WORD_W-1:0] sh_rx_word;
  logic              rx_valid;
  logic [WORD_W-1:0] rx_data;
  logic              rx_ready;

  modport slave (
    input  in_valid, in_data, sh_done, sh_rx_word, rx_ready,
    output in_ready, sh_start, sh_tx_word, rx_valid, rx_data
  );

  modport master (
    output in_valid, in_data, sh_done, sh_rx_word, rx_ready,
    input  in_ready, sh_start, sh_tx_word, rx_valid, rx_data
  );
endinterface

// File: rtl/spi_word_sequencer.sv
// Feeds a 32-bit SPI shifter: buffers outgoing words in a FIFO, launches one shifter
// transaction per word with a start/done handshake, inserts an idle gap between words,
// returns each received word on a valid/ready port and flags overruns and timeouts.
// Ports:
//   clk, rst_n   : clock (posedge) and asynchronous active-low reset
//   bus          : in_*/sh_*/rx_* handshakes (see spi_word_sequencer_if)
//   clear_err    : clears the sticky flags
//   rx_overrun   : sticky, an unconsumed rx word was overwritten
//   timeout_err  : sticky, the shifter did not finish within TIMEOUT cycles
//   busy         : transaction in progress or words still queued
//   words_done   : completed transactions, wrapping 16-bit count
module spi_word_sequencer #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  spi_word_sequencer_if.slave       bus,
  input  logic                      clear_err,
  output logic                      rx_overrun,
  output logic                      timeout_err,
  output logic                      busy,
  output logic [15:0]               words_done
);

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned TIMER_W  = 8;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

  // With no gap configured a finished transaction returns straight to IDLE.
  localparam state_t AFTER_XFER = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t             state;
  logic [WORD_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [TIMER_W-1:0] timer;
  logic [GAP_W-1:0]   gap_cnt;
  logic               push_c;
  logic               pop_c;

  // in_ready depends only on the registered count, so a same-cycle pop never reopens it.
  assign bus.in_ready = (count != CNT_W'(DEPTH));
  assign push_c       = bus.in_valid && bus.in_ready;
  assign pop_c        = (state == START);
  assign busy         = (state != IDLE) || (count != '0);

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // FIFO storage; contents are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= bus.in_data;
  end

  // Sequencer FSM with registered shifter, rx and status outputs.
  // sh_start/sh_tx_word are loaded on entry to START so the pulse coincides with START,
  // giving the two-cycle push-to-start latency and a GAP_CYCLES+1 idle stretch between words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.sh_start   <= 1'b0;
      bus.sh_tx_word <= '0;
      bus.rx_valid   <= 1'b0;
      bus.rx_data    <= '0;
      rx_overrun     <= 1'b0;
      timeout_err    <= 1'b0;
      words_done     <= '0;
      timer          <= '0;
      gap_cnt        <= '0;
    end else begin
      bus.sh_start <= 1'b0;
      if (bus.rx_valid && bus.rx_ready) bus.rx_valid <= 1'b0;
      // Clear first so a set event later in this block wins.
      if (clear_err) begin
        rx_overrun  <= 1'b0;
        timeout_err <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (count != '0) begin
            state          <= START;
            bus.sh_start   <= 1'b1;
            bus.sh_tx_word <= mem[rd_ptr];
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          timer <= timer + TIMER_W'(1);
          if (bus.sh_done) begin
            bus.rx_data  <= bus.sh_rx_word;
            bus.rx_valid <= 1'b1;
            words_done   <= words_done + 16'd1;
            if (bus.rx_valid && !bus.rx_ready) rx_overrun <= 1'b1;
            gap_cnt      <= '0;
            state        <= AFTER_XFER;
          end else if (timer == TIMER_W'(TIMEOUT)) begin
            timeout_err <= 1'b1;
            gap_cnt     <= '0;
            state       <= AFTER_XFER;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_LAST)) state <= IDLE;
          else gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
